// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_if.sv
// Handshake and status bundle between a producer/consumer and fifo_param.
interface fifo_if #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 3
);
  logic                  clr;
  logic                  wr;
  logic [DATA_W-1:0]     din;
  logic                  rd;
  logic [DATA_W-1:0]     dout;
  logic                  valid;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;
  logic                  over;
  logic                  under;

  modport master (
    output clr, wr, din, rd,
    input  dout, valid, count, full, almostfull, empty, almostempty, over, under
  );

  modport slave (
    input  clr, wr, din, rd,
    output dout, valid, count, full, almostfull, empty, almostempty, over, under
  );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module fifo_ram #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 3,
  parameter bit WR_FIRST   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // WR_FIRST forwards same-address write data, used to present a word
  // written into an empty FIFO without waiting a second cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rdata <= '0;
    else if (re)
      rdata <= (WR_FIRST && we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, flush and optional FWFT.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 3,
  parameter int AFULL_TH   = (1 << DEPTH_LOG2) - 1,
  parameter int AEMPTY_TH  = 1,
  parameter int FWFT       = FIFO_STD
) (
  input logic   clk,
  input logic   rst,
  fifo_if.slave bus
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int PTR_W   = clog2(DEPTH);
  localparam int CNT_W   = DEPTH_LOG2 + 1;
  localparam bit IS_FWFT = (FWFT == FIFO_FWFT);

  logic [PTR_W-1:0]  wptr, rptr, rptr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              full, empty, wa, ra;
  logic              valid_q, over_q, under_q;
  logic [DATA_W-1:0] rdata;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // In FWFT the head word is already on dout, so a pop needs valid data.
  assign ra = !bus.clr && bus.rd && (IS_FWFT ? valid_q : !empty);
  assign wa = !bus.clr && bus.wr && (!full || ra);

  assign rptr_nxt = rptr + PTR_W'(ra);

  always_comb begin
    cnt_nxt = cnt;
    case ({wa, ra})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else if (bus.clr) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      wptr    <= wptr + PTR_W'(wa);
      rptr    <= rptr_nxt;
      cnt     <= cnt_nxt;
      valid_q <= IS_FWFT ? (cnt_nxt != '0) : ra;
      over_q  <= bus.wr && !wa;
      under_q <= bus.rd && !ra;
    end
  end

  // FWFT keeps the read port tracking the next head; a write into an empty
  // FIFO collides with that address and is forwarded by the RAM.
  fifo_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WR_FIRST   (IS_FWFT)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wa),
    .waddr (wptr),
    .wdata (bus.din),
    .re    (IS_FWFT ? 1'b1 : ra),
    .raddr (IS_FWFT ? rptr_nxt : rptr),
    .rdata (rdata)
  );

  assign bus.dout        = rdata;
  assign bus.valid       = valid_q;
  assign bus.count       = cnt;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almostfull  = (cnt >= CNT_W'(AFULL_TH));
  assign bus.almostempty = (cnt <= CNT_W'(AEMPTY_TH));
  assign bus.over        = over_q;
  assign bus.under       = under_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: standard-mode and FWFT instances side by side.
module tb_fifo_param;
  import fifo_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fifo_if #(.DATA_W(16), .DEPTH_LOG2(3)) if_std ();
  fifo_if #(.DATA_W(16), .DEPTH_LOG2(3)) if_fw ();

  fifo_param #(.DATA_W(16), .DEPTH_LOG2(3), .AFULL_TH(7), .AEMPTY_TH(1), .FWFT(FIFO_STD)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (if_std)
  );

  fifo_param #(.DATA_W(16), .DEPTH_LOG2(3), .AFULL_TH(7), .AEMPTY_TH(1), .FWFT(FIFO_FWFT)) u_fw (
    .clk (clk),
    .rst (rst),
    .bus (if_fw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_drive(input logic w, input logic r, input logic [15:0] d);
    if_std.wr  = w;
    if_std.rd  = r;
    if_std.din = d;
  endtask

  logic [15:0] q[$];
  logic [15:0] exp_d;
  logic        m_ra, m_wa, w_v, r_v;
  int          n;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    if_std.clr = 0; if_std.wr = 0; if_std.rd = 0; if_std.din = '0;
    if_fw.clr  = 0; if_fw.wr  = 0; if_fw.rd  = 0; if_fw.din  = '0;

    #12;
    chk("rst_count", if_std.count, 0);
    chk("rst_empty", if_std.empty, 1);
    chk("rst_aempty", if_std.almostempty, 1);
    chk("rst_full", if_std.full, 0);
    chk("rst_afull", if_std.almostfull, 0);
    chk("rst_valid", if_std.valid, 0);
    chk("rst_dout", if_std.dout, 0);
    chk("rst_fw_valid", if_fw.valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // write 1..9 into a depth-8 FIFO
    for (int i = 1; i <= 9; i++) begin
      s_drive(1, 0, 16'(i));
      step();
      n = (i > 8) ? 8 : i;
      chk("fill_count", if_std.count, n);
      chk("fill_afull", if_std.almostfull, (n >= 7));
      chk("fill_full", if_std.full, (n == 8));
      chk("fill_over", if_std.over, (i == 9));
    end
    s_drive(0, 0, 0);
    step();
    chk("over_pulse_end", if_std.over, 0);
    chk("full_hold_count", if_std.count, 8);

    // read 9 times from full
    for (int i = 1; i <= 9; i++) begin
      s_drive(0, 1, 0);
      step();
      n = (i > 8) ? 0 : 8 - i;
      chk("drain_count", if_std.count, n);
      chk("drain_empty", if_std.empty, (n == 0));
      chk("drain_aempty", if_std.almostempty, (n <= 1));
      chk("drain_valid", if_std.valid, (i <= 8));
      chk("drain_under", if_std.under, (i == 9));
      if (i <= 8) chk("drain_dout", if_std.dout, i);
    end
    s_drive(0, 0, 0);
    step();
    chk("under_pulse_end", if_std.under, 0);

    // full FIFO with simultaneous write and read
    for (int i = 1; i <= 8; i++) begin
      s_drive(1, 0, 16'(i));
      step();
    end
    chk("refill_full", if_std.full, 1);
    s_drive(1, 1, 16'h00AA);
    step();
    chk("wr_rd_full_over", if_std.over, 0);
    chk("wr_rd_full_count", if_std.count, 8);
    chk("wr_rd_full_dout", if_std.dout, 1);
    chk("wr_rd_full_valid", if_std.valid, 1);
    for (int i = 2; i <= 9; i++) begin
      s_drive(0, 1, 0);
      step();
      chk("order_dout", if_std.dout, (i == 9) ? 32'h00AA : i);
    end
    chk("order_empty", if_std.empty, 1);
    s_drive(0, 0, 0);

    // FWFT instance
    if_fw.wr = 1; if_fw.din = 16'h1234;
    step();
    if_fw.wr = 0;
    chk("fw_dout", if_fw.dout, 16'h1234);
    chk("fw_valid", if_fw.valid, 1);
    step();
    chk("fw_hold_valid", if_fw.valid, 1);
    if_fw.rd = 1;
    step();
    if_fw.rd = 0;
    chk("fw_pop_valid", if_fw.valid, 0);
    chk("fw_pop_count", if_fw.count, 0);
    for (int i = 0; i < 3; i++) begin
      if_fw.wr = 1; if_fw.din = 16'hA0 + 16'(i);
      step();
    end
    if_fw.wr = 0;
    chk("fw_head0", if_fw.dout, 16'hA0);
    for (int i = 1; i <= 3; i++) begin
      if_fw.rd = 1;
      step();
      chk("fw_pop_valid_seq", if_fw.valid, (i < 3));
      if (i < 3) chk("fw_head_seq", if_fw.dout, 16'hA0 + i);
    end
    step();
    if_fw.rd = 0;
    chk("fw_under", if_fw.under, 1);

    // flush with a concurrent write
    for (int i = 0; i < 5; i++) begin
      s_drive(1, 0, 16'h10 + 16'(i));
      step();
    end
    s_drive(0, 1, 0);
    step();
    chk("pre_clr_valid", if_std.valid, 1);
    chk("pre_clr_count", if_std.count, 4);
    s_drive(1, 0, 16'h55);
    if_std.clr = 1;
    step();
    if_std.clr = 0;
    s_drive(0, 0, 0);
    chk("clr_count", if_std.count, 0);
    chk("clr_empty", if_std.empty, 1);
    chk("clr_valid", if_std.valid, 0);
    chk("clr_over", if_std.over, 0);

    // 20 mixed operations against a queue model, then drain
    q.delete();
    for (int k = 0; k < 20; k++) begin
      w_v = (k % 3 != 2);
      r_v = (k % 2 == 1);
      m_ra = r_v && (q.size() != 0);
      m_wa = w_v && ((q.size() < 8) || m_ra);
      exp_d = '0;
      if (m_ra) exp_d = q.pop_front();
      if (m_wa) q.push_back(16'h100 + 16'(k));
      s_drive(w_v, r_v, 16'h100 + 16'(k));
      step();
      chk("mix_count", if_std.count, q.size());
      chk("mix_valid", if_std.valid, m_ra);
      if (m_ra) chk("mix_dout", if_std.dout, exp_d);
    end
    while (q.size() != 0) begin
      exp_d = q.pop_front();
      s_drive(0, 1, 0);
      step();
      chk("mix_drain_dout", if_std.dout, exp_d);
    end
    s_drive(0, 0, 0);
    step();
    chk("mix_empty", if_std.empty, 1);

    // asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) begin
      s_drive(1, 0, 16'h21 + 16'(i));
      step();
    end
    s_drive(0, 1, 0);
    step();
    s_drive(0, 0, 0);
    chk("pre_rst_count", if_std.count, 4);
    chk("pre_rst_dout", if_std.dout, 16'h21);
    #2 rst = 1'b0;
    #1;
    chk("async_count", if_std.count, 0);
    chk("async_empty", if_std.empty, 1);
    chk("async_aempty", if_std.almostempty, 1);
    chk("async_valid", if_std.valid, 0);
    chk("async_dout", if_std.dout, 0);
    chk("async_afull", if_std.almostfull, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    s_drive(1, 0, 16'hBEEF);
    step();
    s_drive(0, 1, 0);
    step();
    s_drive(0, 0, 0);
    chk("post_rst_dout", if_std.dout, 16'hBEEF);
    chk("post_rst_valid", if_std.valid, 1);
    chk("post_rst_count", if_std.count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the team's fixed 16-bit FIFO. Width, depth and almost-full/almost-empty thresholds are configurable, and it adds an occupancy count, a synchronous flush and an optional first-word-fall-through (FWFT) read mode. Over/underflow reporting is kept. It sits between single-clock producer/consumer stages in the datapath.

## Interface
- DATA_W, 16, data width in bits.
- DEPTH_LOG2, 3, log2 of depth; DEPTH = 2**DEPTH_LOG2 entries.
- AFULL_TH, DEPTH-1, almostfull asserted when count >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 1, almostempty asserted when count <= AEMPTY_TH (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserts immediately, releases synchronously to clk by upstream).
- clr  in  1  synchronous flush; empties FIFO, higher priority than wr/rd.
- wr  in  1  write request.
- din  in  DATA_W  write data, sampled with wr.
- rd  in  1  read request (standard) / pop (FWFT).
- dout  out  DATA_W  read data.
- valid  out  1  dout holds valid data.
- count  out  DEPTH_LOG2+1  current occupancy 0..DEPTH.
- full, almostfull, empty, almostempty  out  1  status flags.
- over  out  1  one-cycle pulse: a write was rejected.
- under  out  1  one-cycle pulse: a read was rejected.

## Operation
- Storage: DEPTH-entry array. Write/read pointers are DEPTH_LOG2 bits and wrap naturally modulo DEPTH. count is a separate registered counter.
- Write accepted (wa) = wr & (!full | ra). A full FIFO accepts a write in the same cycle as an accepted read.
- Read accepted (ra):
  - Standard mode: rd & !empty.
  - FWFT mode: rd & valid.
- Rejected wr sets over next cycle; rejected rd sets under next cycle. Each pulse lasts one cycle per rejected request.
- wa & ra together: count unchanged, both pointers advance.
- Flags are combinational from registered count:
  - full = (count == DEPTH), empty = (count == 0).
  - almostfull = (count >= AFULL_TH), almostempty = (count <= AEMPTY_TH).
- Standard mode: on ra, dout <= mem[rptr] and valid = 1 the next cycle. Otherwise valid = 0 and dout holds its last value.
- FWFT mode:
  - The head word is presented on dout with valid = 1 whenever the FIFO holds data.
  - rd pops it; the next word (if any) appears in the following cycle.
  - A word written into an empty FIFO appears on dout one cycle after the write.
- Empty with wr & rd in the same cycle (standard mode): write accepted, read rejected, under = 1.
- clr: pointers and count go to 0, valid = 0, over/under = 0 next cycle. wr/rd in the same cycle are ignored and not flagged.
- Reset (any time, including mid-operation):
  - count = 0, pointers = 0, dout = 0.
  - valid = 0, full = 0, almostfull = 0, over = 0, under = 0.
  - empty = 1, almostempty = 1.
  - Array contents are undefined.

## Timing
- Standard-mode read latency: 1 cycle from rd edge to dout/valid.
- FWFT latency: 1 cycle from write into an empty FIFO to valid = 1.
- count and flags update on the edge that accepts the operation and are visible in the following cycle.
- over/under are registered, high exactly one cycle after the offending edge.
- Throughput: one write and one read per cycle sustained, including at full/empty boundaries as defined above.

## Structure
- Shared package fifo_pkg holds:
  - A clog2 helper function.
  - Mode constants FIFO_STD = 0 and FIFO_FWFT = 1.
- Storage is one sub-module, fifo_ram: simple dual-port array with one write port and one synchronous read port, parametrised by DATA_W/DEPTH_LOG2.
- Pointers, counter, flags and the FWFT output stage live in fifo_param.

## Test plan
- Defaults, standard mode, write 1..9 consecutively:
  - Entries 1..8 accepted.
  - almostfull rises at count 7; full at count 8.
  - 9th write gives over = 1 for one cycle; count stays 8.
- From full, read 9 times:
  - dout = 1..8, each with valid one cycle after its rd.
  - empty at count 0; 9th read gives under = 1, valid = 0.
- Full FIFO, wr & rd same cycle with din = 0x00AA:
  - No over; count stays 8.
  - Data order preserved; 0x00AA is read last.
- FWFT = 1, write 0x1234 into empty FIFO:
  - dout = 0x1234, valid = 1 one cycle later without rd.
  - rd pops it; valid = 0 the next cycle.
- Write 5 words, then pulse clr with wr = 1:
  - count = 0, empty = 1, valid = 0, no over.
  - Subsequent write/read returns the new data, with correct pointer wrap after 20 mixed operations.
- Assert rst low mid-burst at count 4:
  - All outputs take reset values immediately, without waiting for a clock edge.
  - After release, a write then a read returns the written value.
